sha1_base_watchdog: RTL and testbench

SHA1_BASE_WATCHDOG -- requirements
Module: sha1_base_watchdog

---
 rtl/sha1_base_wdt_pkg.sv | 24 ++
 rtl/sha1_base_watchdog_if.sv | 11 +
 rtl/sha1_base_wdt_rst_stretch.sv | 29 ++
 rtl/sha1_base_watchdog.sv | 161 ++++++++++++++++
 tb/tb_sha1_base_watchdog.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha1_base_wdt_pkg.sv
// Shared types and constants for the SHA1 base watchdog: FSM states,
// register addresses and STATUS/CONTROL bit positions.
package sha1_base_wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WARN    = 2'd2,
    ST_EXPIRED = 2'd3
  } wdt_state_e;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd2;
  localparam logic [2:0] ADDR_KICK    = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;
  localparam logic [2:0] ADDR_PREWARN = 3'd5;

  localparam int unsigned STATUS_EXPIRED_BIT = 0;
  localparam int unsigned STATUS_PREWARN_BIT = 1;
  localparam int unsigned CTRL_ENABLE_BIT    = 0;
  localparam int unsigned CTRL_IRQEN_BIT     = 1;

endpackage

// File: rtl/sha1_base_watchdog_if.sv
// Register-bus signals of the watchdog slave port.
interface sha1_base_watchdog_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sha1_base_wdt_rst_stretch.sv
// Turns a single-cycle trigger into a pulse exactly PULSE_CYCLES clocks long.
module sha1_base_wdt_rst_stretch #(
  parameter int unsigned PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger_i,
  output logic pulse_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger_i)
      cnt_d = 8'(PULSE_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Decoded straight from the register so an async reset drops it at once.
  assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/sha1_base_watchdog.sv
// Tick-driven watchdog with kick key, sticky expiry and reset-request pulse.
// Optional pre-warning (WARN state, PREWARN register, irq) under SHA1_BASE_WDT_PREWARN_EN.
module sha1_base_watchdog
  import sha1_base_wdt_pkg::*;
#(
  parameter logic [15:0] KICK_KEY         = 16'h5A5A,
  parameter logic [15:0] TIMEOUT_RST      = 16'd1000,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sha1_base_watchdog_if.slave  bus,
  input  logic                 tick,
  output logic                 irq,
  output logic                 resetrequest
);

  wdt_state_e  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] timeout_q, timeout_d;
  logic [15:0] readdata_q, readdata_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic        expired_q, expired_d;
  logic        wr, kick_ok, expire_trig;
  logic [15:0] count_dec;

`ifdef SHA1_BASE_WDT_PREWARN_EN
  logic [15:0] prewarn_q, prewarn_d;
  logic        flag_q, flag_d;
`else
  logic [15:0] prewarn_q;
  logic        flag_q;
  assign prewarn_q = '0;
  assign flag_q    = 1'b0;
`endif

  assign wr        = bus.chipselect && !bus.write_n;
  assign kick_ok   = wr && (bus.address == ADDR_KICK) && (bus.writedata == KICK_KEY);
  assign count_dec = count_q - 16'd1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
`ifdef SHA1_BASE_WDT_PREWARN_EN
    prewarn_d = prewarn_q;
    flag_d    = flag_q;
    // Clear first so a same-cycle RUN->WARN transition still sets the flag.
    if (wr && bus.address == ADDR_STATUS && bus.writedata[STATUS_PREWARN_BIT])
      flag_d = 1'b0;
`endif
    if (wr && bus.address == ADDR_CONTROL)
      irq_en_d = bus.writedata[CTRL_IRQEN_BIT];

    case (state_q)
      ST_IDLE: begin
        if (wr && bus.address == ADDR_TIMEOUT)
          timeout_d = bus.writedata;
`ifdef SHA1_BASE_WDT_PREWARN_EN
        if (wr && bus.address == ADDR_PREWARN)
          prewarn_d = bus.writedata;
`endif
        if (wr && bus.address == ADDR_CONTROL && bus.writedata[CTRL_ENABLE_BIT]) begin
          enable_d = 1'b1;
          count_d  = timeout_q;
          state_d  = ST_RUN;
        end
      end
      ST_RUN, ST_WARN: begin
        if (kick_ok) begin
          count_d = timeout_q;
          state_d = ST_RUN;
        end else if (tick) begin
          if (count_q == '0) begin
            state_d   = ST_EXPIRED;
            expired_d = 1'b1;
          end else begin
            count_d = count_dec;
`ifdef SHA1_BASE_WDT_PREWARN_EN
            if (state_q == ST_RUN && prewarn_q != '0 && count_dec <= prewarn_q) begin
              state_d = ST_WARN;
              flag_d  = 1'b1;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS: begin
        readdata_d[STATUS_EXPIRED_BIT] = expired_q;
        readdata_d[STATUS_PREWARN_BIT] = flag_q;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_ENABLE_BIT] = enable_q;
        readdata_d[CTRL_IRQEN_BIT]  = irq_en_q;
      end
      ADDR_TIMEOUT: readdata_d = timeout_q;
      ADDR_COUNT:   readdata_d = count_q;
      ADDR_PREWARN: readdata_d = prewarn_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= TIMEOUT_RST;
      timeout_q  <= TIMEOUT_RST;
      readdata_q <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      readdata_q <= readdata_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
    end
  end

`ifdef SHA1_BASE_WDT_PREWARN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prewarn_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      prewarn_q <= prewarn_d;
      flag_q    <= flag_d;
    end
  end
  assign irq = flag_q && irq_en_q;
`else
  assign irq = 1'b0;
`endif

  assign bus.readdata = readdata_q;
  assign expire_trig  = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);

  sha1_base_wdt_rst_stretch #(
    .PULSE_CYCLES(RST_PULSE_CYCLES)
  ) u_rst_stretch (
    .clk       (clk),
    .rst       (reset),
    .trigger_i (expire_trig),
    .pulse_o   (resetrequest)
  );

endmodule

// File: tb/tb_sha1_base_watchdog.sv
// Self-checking bench for sha1_base_watchdog: register table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_sha1_base_watchdog;

  localparam int unsigned PULSE = 16;
  localparam logic [15:0] KEY   = 16'h5A5A;
  localparam logic [15:0] TRST  = 16'd1000;
`ifdef SHA1_BASE_WDT_PREWARN_EN
  localparam bit PW = 1'b1;
`else
  localparam bit PW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic irq;
  logic resetrequest;

  sha1_base_watchdog_if bus();

  sha1_base_watchdog #(
    .KICK_KEY(KEY),
    .TIMEOUT_RST(TRST),
    .RST_PULSE_CYCLES(PULSE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .tick(tick),
    .irq(irq),
    .resetrequest(resetrequest)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: plain variables describing the watchdog's visible state.
  bit          m_enable, m_irq_en, m_flag, m_expired, m_warn;
  logic [15:0] m_count, m_timeout, m_prewarn;
  int          m_rr_left;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_enable = 0; m_irq_en = 0; m_flag = 0; m_expired = 0; m_warn = 0;
    m_count = TRST; m_timeout = TRST; m_prewarn = '0; m_rr_left = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {14'b0, m_flag, m_expired};
      3'd1: return {14'b0, m_irq_en, m_enable};
      3'd2: return m_timeout;
      3'd4: return m_count;
      3'd5: return PW ? m_prewarn : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_update(input logic [2:0] a, input bit cs, input bit wn,
                              input logic [15:0] wd, input bit tk);
    bit w;
    bit entering;
    w = cs && !wn;
    entering = 0;
    if (PW && w && a == 3'd0 && wd[1]) m_flag = 0;
    if (!m_enable) begin
      if (w && a == 3'd2) m_timeout = wd;
      if (PW && w && a == 3'd5) m_prewarn = wd;
      if (w && a == 3'd1) begin
        m_irq_en = wd[1];
        if (wd[0]) begin m_enable = 1; m_count = m_timeout; end
      end
    end else begin
      if (w && a == 3'd1) m_irq_en = wd[1];
      if (!m_expired) begin
        if (w && a == 3'd3 && wd == KEY) begin
          m_count = m_timeout; m_warn = 0;
        end else if (tk) begin
          if (m_count == 16'd0) begin
            m_expired = 1; entering = 1;
          end else begin
            m_count = m_count - 16'd1;
            if (PW && !m_warn && m_prewarn != 16'd0 && m_count <= m_prewarn) begin
              m_warn = 1; m_flag = 1;
            end
          end
        end
      end
    end
    m_rr_left = entering ? int'(PULSE) : (m_rr_left > 0 ? m_rr_left - 1 : 0);
  endtask

  // One clock cycle: drive at negedge, model the posedge, sample at next negedge.
  task automatic step(input logic [2:0] a, input bit cs, input bit wn,
                      input logic [15:0] wd, input bit tk, output logic [15:0] rd);
    logic [15:0] exp_rd;
    bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd; tick = tk;
    exp_rd = model_read(a);
    model_update(a, cs, wn, wd, tk);
    @(negedge clk);
    check("readdata", bus.readdata, exp_rd);
    check("irq", {15'b0, irq}, {15'b0, PW && m_flag && m_irq_en});
    check("resetrequest", {15'b0, resetrequest}, {15'b0, m_rr_left > 0});
    rd = bus.readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    logic [15:0] rd;
    step(a, 1'b1, 1'b0, d, 1'b0, rd);
  endtask

  task automatic rdreg(input logic [2:0] a, output logic [15:0] rd);
    step(a, 1'b1, 1'b1, 16'h0, 1'b0, rd);
  endtask

  task automatic idle(input bit tk);
    logic [15:0] rd;
    step(3'd0, 1'b0, 1'b1, 16'h0, tk, rd);
  endtask

  task automatic do_reset();
    bus.address = '0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = '0; tick = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    model_reset();
    check("reset_readdata", bus.readdata, 16'h0);
    check("reset_irq", {15'b0, irq}, 16'h0);
    check("reset_rr", {15'b0, resetrequest}, 16'h0);
    reset = 0;
  endtask

  typedef struct {
    logic [2:0]  a;
    bit          w;
    logic [15:0] wd;
    bit          tk;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] rd;
    int n;
    int minc;

    tbl.push_back('{3'd0, 0, 16'h0000, 0, 16'h0000});
    tbl.push_back('{3'd1, 0, 16'h0000, 0, 16'h0000});
    tbl.push_back('{3'd2, 0, 16'h0000, 0, 16'h03E8});
    tbl.push_back('{3'd4, 0, 16'h0000, 0, 16'h03E8});
    tbl.push_back('{3'd5, 0, 16'h0000, 0, 16'h0000});
    tbl.push_back('{3'd3, 0, 16'h0000, 0, 16'h0000});
    tbl.push_back('{3'd2, 1, 16'h0007, 0, 16'h03E8});
    tbl.push_back('{3'd2, 0, 16'h0000, 0, 16'h0007});
    tbl.push_back('{3'd4, 0, 16'h0000, 1, 16'h03E8});
    tbl.push_back('{3'd6, 1, 16'hFFFF, 0, 16'h0000});
    tbl.push_back('{3'd7, 0, 16'h0000, 0, 16'h0000});
    tbl.push_back('{3'd1, 1, 16'h0002, 0, 16'h0000});
    tbl.push_back('{3'd1, 0, 16'h0000, 0, 16'h0002});
    tbl.push_back('{3'd1, 1, 16'h0001, 0, 16'h0002});
    tbl.push_back('{3'd4, 0, 16'h0000, 0, 16'h0007});
    tbl.push_back('{3'd1, 0, 16'h0000, 0, 16'h0001});
    tbl.push_back('{3'd1, 1, 16'h0000, 0, 16'h0001});
    tbl.push_back('{3'd1, 0, 16'h0000, 0, 16'h0001});
    tbl.push_back('{3'd2, 1, 16'h0003, 0, 16'h0007});
    tbl.push_back('{3'd2, 0, 16'h0000, 0, 16'h0007});
    tbl.push_back('{3'd4, 0, 16'h0000, 1, 16'h0007});
    tbl.push_back('{3'd4, 0, 16'h0000, 0, 16'h0006});

    reset = 1;
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].a, 1'b1, !tbl[i].w, tbl[i].wd, tbl[i].tk, rd);
      check($sformatf("table[%0d]", i), rd, tbl[i].exp_rd);
    end

    // Expiry with no kicks, pulse length, sticky status, expired ignores kick/tick.
    do_reset();
    wr(3'd2, 16'd3); wr(3'd1, 16'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("expire_rr_rise", {15'b0, resetrequest}, 16'h1);
    n = 1;
    for (int i = 0; i < 40 && resetrequest; i++) begin
      idle(1'b0);
      if (resetrequest) n++;
    end
    check("pulse_length", 16'(n), 16'(PULSE));
    rdreg(3'd0, rd); check("expire_status", rd, 16'h0001);
    step(3'd3, 1'b1, 1'b0, KEY, 1'b1, rd);
    rdreg(3'd4, rd); check("expired_count_frozen", rd, 16'h0000);
    rdreg(3'd0, rd); check("expired_sticky", rd, 16'h0001);

    // Periodic valid kicks keep the count at or above 2.
    do_reset();
    wr(3'd2, 16'd5); wr(3'd1, 16'd1);
    minc = 99;
    for (int t = 1; t <= 30; t++) begin
      idle(1'b1);
      rdreg(3'd4, rd);
      if (int'(rd) < minc) minc = int'(rd);
      if (t % 3 == 0) wr(3'd3, KEY);
    end
    check("kick_min_count", 16'(minc), 16'd2);
    rdreg(3'd0, rd); check("kick_no_expiry", rd, 16'h0000);

    // Wrong key is ignored.
    do_reset();
    wr(3'd2, 16'd5); wr(3'd1, 16'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    rdreg(3'd4, rd); check("badkey_pre", rd, 16'd2);
    wr(3'd3, 16'h1234);
    rdreg(3'd4, rd); check("badkey_post", rd, 16'd2);
    idle(1'b1); idle(1'b1);
    check("badkey_no_rr_yet", {15'b0, resetrequest}, 16'h0);
    idle(1'b1);
    check("badkey_expire", {15'b0, resetrequest}, 16'h1);

    // Kick and tick together at count 0: kick wins.
    do_reset();
    wr(3'd2, 16'd2); wr(3'd1, 16'd1);
    idle(1'b1); idle(1'b1);
    step(3'd3, 1'b1, 1'b0, KEY, 1'b1, rd);
    rdreg(3'd4, rd); check("kick_tick_count", rd, 16'd2);
    check("kick_tick_no_rr", {15'b0, resetrequest}, 16'h0);
    idle(1'b1);
    rdreg(3'd4, rd); check("kick_tick_running", rd, 16'd1);

    // Pre-warning behaviour.
    do_reset();
    wr(3'd2, 16'd10); wr(3'd5, 16'd4); wr(3'd1, 16'd3);
    if (PW) begin
      for (int i = 0; i < 5; i++) idle(1'b1);
      check("pw_irq_low_at5", {15'b0, irq}, 16'h0);
      idle(1'b1);
      check("pw_irq_at4", {15'b0, irq}, 16'h1);
      rdreg(3'd0, rd); check("pw_status", rd, 16'h0002);
      wr(3'd0, 16'h0002);
      check("pw_irq_cleared", {15'b0, irq}, 16'h0);
      wr(3'd3, KEY);
      rdreg(3'd4, rd); check("pw_kick_reload", rd, 16'd10);
      for (int i = 0; i < 6; i++) idle(1'b1);
      check("pw_rewarn", {15'b0, irq}, 16'h1);
    end else begin
      rdreg(3'd5, rd); check("nopw_prewarn_reads0", rd, 16'h0);
      for (int i = 0; i < 7; i++) idle(1'b1);
      check("nopw_irq", {15'b0, irq}, 16'h0);
      rdreg(3'd0, rd); check("nopw_status", rd, 16'h0);
    end

    // TIMEOUT=0 expires on the first tick; async reset mid-pulse.
    do_reset();
    wr(3'd2, 16'd0); wr(3'd1, 16'd1);
    idle(1'b1);
    check("zero_timeout_expire", {15'b0, resetrequest}, 16'h1);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("pulse_cycle5", {15'b0, resetrequest}, 16'h1);
    #2 reset = 1;
    #1 check("async_rr_drop", {15'b0, resetrequest}, 16'h0);
    @(negedge clk);
    model_reset();
    check("async_reset_readdata", bus.readdata, 16'h0);
    reset = 0;
    rdreg(3'd0, rd); check("post_reset_status", rd, 16'h0);
    rdreg(3'd1, rd); check("post_reset_control", rd, 16'h0);
    rdreg(3'd2, rd); check("post_reset_timeout", rd, TRST);
    idle(1'b1);
    rdreg(3'd4, rd); check("post_reset_idle_count", rd, TRST);

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      bit tk;
      int op;
      tk = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 9);
      if ((m_expired && m_rr_left == 0 && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        case (op)
          0, 1, 2: step(3'($urandom_range(0, 7)), 1'b1, 1'b1, 16'h0, tk, rd);
          3: step(3'($urandom_range(0, 7)), 1'b0, 1'b0, 16'($urandom), tk, rd);
          4: step(3'd2, 1'b1, 1'b0, 16'($urandom_range(0, 6)), tk, rd);
          5: step(3'd5, 1'b1, 1'b0, 16'($urandom_range(0, 5)), tk, rd);
          6: step(3'd1, 1'b1, 1'b0, 16'($urandom_range(0, 3)), tk, rd);
          7: step(3'd3, 1'b1, 1'b0, ($urandom_range(0, 4) != 0) ? KEY : 16'($urandom), tk, rd);
          8: step(3'd0, 1'b1, 1'b0, 16'($urandom_range(0, 3)), tk, rd);
          default: step(3'($urandom_range(6, 7)), 1'b1, 1'b0, 16'($urandom), tk, rd);
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
